cdss_seq: RTL and testbench

Parametrised, sequential successor of the 4-bit add/sub–compare–shift–decode datapath. Accepts one operation per transaction over a valid/ready handshake and computes a W-bit signed sum/difference with overflow. It performs a compare-steered arithmetic/logical shift iteratively at one bit per cycle, and decodes the result's low bits to one-hot. An internal accumulator allows chained operations. It sits between the operand source and any result consumer that needs back-pressure.

---
 rtl/cdss_pkg.sv | 25 ++
 rtl/cdss_seq_addsub_n.sv | 27 ++
 rtl/cdss_seq.sv | 107 ++++++++++
 tb/tb_cdss_seq.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/cdss_pkg.sv
// Shared types for the sequential add/sub-compare-shift-decode block.
package cdss_pkg;

  typedef enum logic [1:0] {
    OP_ADD     = 2'b00,
    OP_SUB     = 2'b01,
    OP_ACC_ADD = 2'b10,
    OP_ACC_SUB = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  function automatic logic op_uses_acc(input op_e o);
    return (o == OP_ACC_ADD) || (o == OP_ACC_SUB);
  endfunction

  function automatic logic op_is_sub(input op_e o);
    return (o == OP_SUB) || (o == OP_ACC_SUB);
  endfunction

endpackage

// File: rtl/cdss_seq_addsub_n.sv
// Ripple-carry adder/subtractor; subtraction is x + ~y + 1 via the carry-in.
module addsub_n #(
  parameter int unsigned W = 8
) (
  input  logic         sub,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         c_msb_in
);

  logic [W:0]   w_c;
  logic [W-1:0] w_y;

  assign w_y    = y ^ {W{sub}};
  assign w_c[0] = sub;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s[i]     = x[i] ^ w_y[i] ^ w_c[i];
    assign w_c[i+1] = (x[i] & w_y[i]) | (w_c[i] & (x[i] ^ w_y[i]));
  end

  assign cout     = w_c[W];
  assign c_msb_in = w_c[W-1];

endmodule

// File: rtl/cdss_seq.sv
// Sequential add/sub with accumulator, compare-steered bit-serial shifter,
// one-hot decode of the result LSBs and a sticky overflow flag.
module cdss_seq
  import cdss_pkg::*;
#(
  parameter  int unsigned W        = 8,
  parameter  int unsigned DEC_BITS = 4,
  localparam int unsigned SHW      = $clog2(W),
  localparam int unsigned DW       = 2**DEC_BITS
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:0]     op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [SHW-1:0] sh_amt,
  input  logic           clr_sticky,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   s,
  output logic           ovf,
  output logic [W-1:0]   t,
  output logic [DW-1:0]  d,
  output logic           ovf_sticky
);

  state_e         r_state, w_state_nxt;
  logic [W-1:0]   r_s, r_t, r_acc;
  logic           r_ovf, r_sticky, r_shr;
  logic [DW-1:0]  r_d;
  logic [SHW-1:0] r_cnt;

  logic [W-1:0]   w_x, w_sum;
  logic           w_cout, w_cmsb, w_accept, w_deliver, w_gt;
  op_e            w_op;

  assign w_op      = op_e'(op);
  assign w_x       = op_uses_acc(w_op) ? r_acc : a;
  assign w_gt      = $signed(w_x) > $signed(b);
  assign w_accept  = in_valid && (r_state == S_IDLE);
  assign w_deliver = (r_state == S_DONE) && out_ready;

  addsub_n #(.W(W)) u_addsub (
    .sub      (op_is_sub(w_op)),
    .x        (w_x),
    .y        (b),
    .s        (w_sum),
    .cout     (w_cout),
    .c_msb_in (w_cmsb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (in_valid) w_state_nxt = (sh_amt != '0) ? S_SHIFT : S_DONE;
      S_SHIFT: if (r_cnt == SHW'(1)) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: capture at accept, then shift one bit per SHIFT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s      <= '0;
      r_ovf    <= 1'b0;
      r_t      <= '0;
      r_d      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_shr    <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      if (w_accept) begin
        r_s   <= w_sum;
        r_ovf <= w_cout ^ w_cmsb;
        r_acc <= w_sum;
        r_d   <= DW'(1) << w_sum[DEC_BITS-1:0];
        r_cnt <= sh_amt;
        r_shr <= w_gt;
        r_t   <= w_gt ? w_x : b;
      end else if (r_state == S_SHIFT) begin
        r_cnt <= r_cnt - SHW'(1);
        r_t   <= r_shr ? {r_t[W-1], r_t[W-1:1]} : {r_t[W-2:0], 1'b0};
      end
      // A delivered overflow beats a concurrent clear.
      if (w_deliver && r_ovf) r_sticky <= 1'b1;
      else if (clr_sticky)    r_sticky <= 1'b0;
    end
  end

  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = (r_state == S_DONE);
  assign s          = r_s;
  assign ovf        = r_ovf;
  assign t          = r_t;
  assign d          = r_d;
  assign ovf_sticky = r_sticky;

endmodule

// File: tb/tb_cdss_seq.sv
// Directed plus random transactions against an arithmetic reference model.
module tb_cdss_seq;

  localparam int unsigned W   = 8;
  localparam int unsigned DB  = 4;
  localparam int unsigned SHW = 3;
  localparam int unsigned DW  = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [1:0]     op = '0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic [SHW-1:0] sh_amt = '0;
  logic           clr_sticky = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   s, t;
  logic           ovf, ovf_sticky;
  logic [DW-1:0]  d;

  int errs = 0;
  int checks = 0;

  logic [7:0]  m_acc = '0;
  logic        m_sticky = 1'b0;
  logic [7:0]  e_s, e_t;
  logic        e_ovf;
  logic [15:0] e_d;

  cdss_seq #(.W(W), .DEC_BITS(DB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .a          (a),
    .b          (b),
    .sh_amt     (sh_amt),
    .clr_sticky (clr_sticky),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .s          (s),
    .ovf        (ovf),
    .t          (t),
    .d          (d),
    .ovf_sticky (ovf_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain signed integer arithmetic on the operands.
  function automatic void model(input logic [1:0] o, input logic [7:0] ai,
                                input logic [7:0] bi, input int sh);
    int x, y, r;
    x = o[1] ? int'($signed(m_acc)) : int'($signed(ai));
    y = int'($signed(bi));
    r = o[0] ? x - y : x + y;
    e_ovf = (r > 127) || (r < -128);
    e_s   = 8'(r);
    e_t   = (x > y) ? 8'(x >>> sh) : 8'(y << sh);
    e_d   = 16'(1) << e_s[3:0];
    m_acc = e_s;
  endfunction

  task automatic do_op(input logic [1:0] o, input logic [7:0] ai, input logic [7:0] bi,
                       input int sh, input int stall, input logic clr, input string tag,
                       input logic kchk, input logic [7:0] ks, input logic kovf,
                       input logic [7:0] kt, input logic [15:0] kd);
    model(o, ai, bi, sh);
    chk({tag, "/in_ready_idle"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; op = o; a = ai; b = bi; sh_amt = SHW'(sh);
    step();
    in_valid = 1'b0; op = 2'($urandom); a = 8'($urandom); b = 8'($urandom);
    sh_amt = SHW'($urandom);
    for (int k = 0; k < sh; k++) begin
      chk({tag, "/out_valid_early"}, 64'(out_valid), 64'd0);
      chk({tag, "/in_ready_busy"}, 64'(in_ready), 64'd0);
      step();
    end
    chk({tag, "/out_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "/s"}, 64'(s), 64'(e_s));
    chk({tag, "/ovf"}, 64'(ovf), 64'(e_ovf));
    chk({tag, "/t"}, 64'(t), 64'(e_t));
    chk({tag, "/d"}, 64'(d), 64'(e_d));
    if (kchk) begin
      chk({tag, "/s_const"}, 64'(s), 64'(ks));
      chk({tag, "/ovf_const"}, 64'(ovf), 64'(kovf));
      chk({tag, "/t_const"}, 64'(t), 64'(kt));
      chk({tag, "/d_const"}, 64'(d), 64'(kd));
    end
    for (int k = 0; k < stall; k++) begin
      in_valid = 1'b1;
      step();
      chk({tag, "/hold_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "/hold_in_ready"}, 64'(in_ready), 64'd0);
      chk({tag, "/hold_s"}, 64'(s), 64'(e_s));
      chk({tag, "/hold_t"}, 64'(t), 64'(e_t));
      chk({tag, "/hold_d"}, 64'(d), 64'(e_d));
    end
    out_ready = 1'b1; clr_sticky = clr;
    step();
    out_ready = 1'b0; clr_sticky = 1'b0; in_valid = 1'b0;
    m_sticky = e_ovf ? 1'b1 : (clr ? 1'b0 : m_sticky);
    chk({tag, "/in_ready_after"}, 64'(in_ready), 64'd1);
    chk({tag, "/out_valid_after"}, 64'(out_valid), 64'd0);
    chk({tag, "/sticky"}, 64'(ovf_sticky), 64'(m_sticky));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    step();
    chk("reset/in_ready", 64'(in_ready), 64'd1);
    chk("reset/out_valid", 64'(out_valid), 64'd0);
    chk("reset/s", 64'(s), 64'd0);
    chk("reset/t", 64'(t), 64'd0);
    chk("reset/d", 64'(d), 64'd0);
    chk("reset/ovf", 64'(ovf), 64'd0);
    chk("reset/sticky", 64'(ovf_sticky), 64'd0);
    rst_n = 1'b1;
    step();

    do_op(2'b00, 8'd100, 8'd27, 0, 0, 1'b0, "add127", 1'b1, 8'h7F, 1'b0, 8'd100, 16'h8000);
    do_op(2'b00, 8'd100, 8'd28, 0, 0, 1'b0, "add_ovf", 1'b1, 8'h80, 1'b1, 8'd100, 16'h0001);
    chk("sticky_set", 64'(ovf_sticky), 64'd1);
    do_op(2'b00, 8'd127, 8'd1, 0, 0, 1'b1, "ovf_vs_clr", 1'b1, 8'h80, 1'b1, 8'h7F, 16'h0001);
    chk("sticky_set_wins", 64'(ovf_sticky), 64'd1);
    do_op(2'b01, 8'hFD, 8'd5, 2, 0, 1'b1, "sub", 1'b1, 8'hF8, 1'b0, 8'd20, 16'h0100);
    chk("sticky_cleared", 64'(ovf_sticky), 64'd0);
    do_op(2'b00, 8'd10, 8'd5, 0, 0, 1'b0, "chain0", 1'b1, 8'h0F, 1'b0, 8'd10, 16'h8000);
    do_op(2'b11, 8'd0, 8'd20, 1, 0, 1'b0, "chain1", 1'b1, 8'hFB, 1'b0, 8'd40, 16'h0800);
    do_op(2'b10, 8'd0, 8'h80, 0, 0, 1'b0, "chain2", 1'b1, 8'h7B, 1'b1, 8'hFB, 16'h0800);
    do_op(2'b00, 8'hC0, 8'hBF, 3, 5, 1'b0, "bp", 1'b1, 8'h7F, 1'b1, 8'hF8, 16'h8000);

    // Abort mid-shift with reset.
    in_valid = 1'b1; op = 2'b00; a = 8'd3; b = 8'd9; sh_amt = 3'd7;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("rst_mid/out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid/in_ready", 64'(in_ready), 64'd1);
    chk("rst_mid/s", 64'(s), 64'd0);
    chk("rst_mid/t", 64'(t), 64'd0);
    chk("rst_mid/d", 64'(d), 64'd0);
    chk("rst_mid/sticky", 64'(ovf_sticky), 64'd0);
    step();
    rst_n = 1'b1;
    m_acc = '0; m_sticky = 1'b0;
    step();
    do_op(2'b10, 8'd77, 8'd5, 0, 0, 1'b0, "post_rst", 1'b1, 8'd5, 1'b0, 8'd5, 16'h0020);

    for (int i = 0; i < 150; i++) begin
      do_op(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
            1'($urandom_range(0, 3) == 0), "rand", 1'b0, 8'd0, 1'b0, 8'd0, 16'd0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
